logic_unit_arbiter: RTL and testbench

//   Shares one 32-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters.

---
 rtl/logic_unit_arbiter_pkg.sv | 21 ++
 rtl/logic_unit_arbiter_logic_unit_32.sv | 34 +++
 rtl/logic_unit_arbiter.sv | 93 +++++++++
 tb/tb_logic_unit_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/logic_unit_arbiter_pkg.sv
// Shared widths and op-code constants for the logic-unit arbiter and its
// control-side users.
package logic_unit_arbiter_pkg;

   localparam int WIDTH = 32;
   localparam int OPW   = 2;

   typedef enum logic [OPW-1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_XOR = 2'b10,
      OP_NOR = 2'b11
   } op_e;

   typedef struct packed {
      op_e              op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } req_t;

endpackage

// File: rtl/logic_unit_arbiter_logic_unit_32.sv
// Combinational 32-bit bitwise logic unit: parallel AND/OR/XOR/NOR arrays
// followed by a fully decoded 4:1 select.
module logic_unit_32
   import logic_unit_arbiter_pkg::*;
(
   input  op_e              op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   logic [WIDTH-1:0] and_y;
   logic [WIDTH-1:0] or_y;
   logic [WIDTH-1:0] xor_y;
   logic [WIDTH-1:0] nor_y;

   assign and_y = a & b;
   assign or_y  = a | b;
   assign xor_y = a ^ b;
   assign nor_y = ~or_y;

   always_comb begin
      // NOTE: give every always_comb output a value before any branch so no
      // path leaves it unassigned and a latch is never inferred.
      y = and_y;
      unique case (op)
         OP_AND: y = and_y;
         OP_OR:  y = or_y;
         OP_XOR: y = xor_y;
         OP_NOR: y = nor_y;
      endcase
   end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic unit between two valid/ready
// requesters, with a 1-entry registered result slot.
module logic_unit_arbiter
   import logic_unit_arbiter_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [OPW-1:0]   req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [OPW-1:0]   req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_id
);

   logic             rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic             rsp_id_q, rsp_id_d;
   logic             last_grant_q, last_grant_d;

   logic             slot_free;
   logic             gnt0, gnt1, xfer, sel_id;
   req_t             sel_req;
   logic [WIDTH-1:0] lu_y;

   assign slot_free = !rsp_valid_q || rsp_ready;

   // On a tie the requester that did not win last time gets the unit.
   assign gnt0 = !reset && slot_free && req0_valid && (!req1_valid || last_grant_q);
   assign gnt1 = !reset && slot_free && req1_valid && (!req0_valid || !last_grant_q);
   assign xfer   = gnt0 || gnt1;
   assign sel_id = gnt1;

   always_comb begin
      sel_req = '{op: op_e'(req0_op), a: req0_a, b: req0_b};
      if (sel_id) begin
         sel_req = '{op: op_e'(req1_op), a: req1_a, b: req1_b};
      end
   end

   logic_unit_32 u_logic_unit (
      .op (sel_req.op),
      .a  (sel_req.a),
      .b  (sel_req.b),
      .y  (lu_y)
   );

   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_id_d     = rsp_id_q;
      last_grant_d = last_grant_q;
      if (xfer) begin
         rsp_valid_d  = 1'b1;
         rsp_result_d = lu_y;
         rsp_id_d     = sel_id;
         last_grant_d = sel_id;
      end else if (rsp_ready) begin
         rsp_valid_d  = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_id_q     <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_id_q     <= rsp_id_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_id     = rsp_id_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench for logic_unit_arbiter with hand-computed
// expected results.
module tb_logic_unit_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req0_ready;
   logic [1:0]  req0_op;
   logic [31:0] req0_a, req0_b;
   logic        req1_valid, req1_ready;
   logic [1:0]  req1_op;
   logic [31:0] req1_a, req1_b;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_id;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   logic_unit_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_id     (rsp_id)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, act, exp);
      end
   endtask

   // Advance one edge and settle so registered outputs are sampled away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_rsp(input string tag, input logic v, input logic [31:0] r, input logic id);
      check({tag, ".valid"},  32'(rsp_valid),  32'(v));
      check({tag, ".result"}, rsp_result,      r);
      check({tag, ".id"},     32'(rsp_id),     32'(id));
   endtask

   task automatic check_rdy(input string tag, input logic r0, input logic r1);
      #1;
      check({tag, ".ready0"}, 32'(req0_ready), 32'(r0));
      check({tag, ".ready1"}, 32'(req1_ready), 32'(r1));
   endtask

   initial begin
      reset = 1'b1;
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'hFFFF0000; req0_b = 32'h0F0F0F0F;
      req1_valid = 1'b1; req1_op = 2'b10; req1_a = 32'hAAAAAAAA; req1_b = 32'hAAAAAAAA;

      // 1. Reset for two cycles with both requesters valid.
      check_rdy("rst_c0", 1'b0, 1'b0);
      tick();
      check_rdy("rst_c1", 1'b0, 1'b0);
      tick();
      check_rsp("rst_out", 1'b0, 32'h0, 1'b0);
      reset = 1'b0;

      // 2. Only requester 0: OR.
      req1_valid = 1'b0;
      req0_op = 2'b01; req0_a = 32'hF0F00000; req0_b = 32'h00000F0F;
      check_rdy("solo0", 1'b1, 1'b0);
      tick();
      check_rsp("solo0_out", 1'b1, 32'hF0F00F0F, 1'b0);

      // 3. Both valid every cycle. Requester 0 won last, so requester 1 leads.
      req0_op = 2'b00; req0_a = 32'hFFFF0000; req0_b = 32'h0F0F0F0F;
      req1_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         logic g1;
         g1 = (i % 2 == 0);
         check_rdy($sformatf("rr%0d", i), !g1, g1);
         tick();
         check_rsp($sformatf("rr%0d_out", i), 1'b1, g1 ? 32'h00000000 : 32'h0F0F0000, g1);
      end

      // 4. Backpressure with requester 1 pending, then release without a bubble.
      req0_valid = 1'b0;
      req1_op = 2'b01; req1_a = 32'h000000FF; req1_b = 32'h0000FF00;
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_rdy($sformatf("hold%0d", i), 1'b0, 1'b0);
         tick();
         check_rsp($sformatf("hold%0d_out", i), 1'b1, 32'h0F0F0000, 1'b0);
      end
      rsp_ready = 1'b1;
      check_rdy("release", 1'b0, 1'b1);
      tick();
      check_rsp("release_out", 1'b1, 32'h0000FFFF, 1'b1);

      // 5. NOR and XOR from requester 0.
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_op = 2'b11; req0_a = 32'h00000000; req0_b = 32'h0000FFFF;
      check_rdy("nor", 1'b1, 1'b0);
      tick();
      check_rsp("nor_out", 1'b1, 32'hFFFF0000, 1'b0);
      req0_op = 2'b10; req0_a = 32'h12345678; req0_b = 32'hFFFFFFFF;
      tick();
      check_rsp("xor_out", 1'b1, 32'hEDCBA987, 1'b0);

      // 6. Reset while holding a result; afterwards requester 0 wins the tie.
      req0_valid = 1'b0;
      rsp_ready = 1'b0;
      tick();
      check_rsp("pre_rst_hold", 1'b1, 32'hEDCBA987, 1'b0);
      reset = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
      req0_op = 2'b00; req0_a = 32'hFFFF0000; req0_b = 32'h0F0F0F0F;
      check_rdy("mid_rst", 1'b0, 1'b0);
      tick();
      check_rsp("mid_rst_out", 1'b0, 32'h0, 1'b0);
      reset = 1'b0;
      check_rdy("post_rst_tie", 1'b1, 1'b0);
      tick();
      check_rsp("post_rst_out", 1'b1, 32'h0F0F0000, 1'b0);

      // Drain with no new transfer: valid drops, data holds.
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      check_rsp("drain", 1'b0, 32'h0F0F0000, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
